// File: rtl/mem_access_pkg.sv
// Shared definitions for the EX/ME data-memory access unit.
// Includes control-word bit positions, access size codes, FSM states and byte-lane helpers.
package mem_access_pkg;

    localparam int CTRL_READ     = 0;
    localparam int CTRL_WRITE    = 1;
    localparam int CTRL_SIZE_LO  = 2;
    localparam int CTRL_SIZE_HI  = 3;
    localparam int CTRL_UNSIGNED = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Little-endian lane selection; lane k covers bits 8k+7:8k of the memory word
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: lane_enable = 4'b0001 << offset;
            SIZE_HALF: lane_enable = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_enable = 4'b1111;
            default:   lane_enable = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] value);
        case (size)
            SIZE_BYTE: lane_data = {4{value[7:0]}};
            SIZE_HALF: lane_data = {2{value[15:0]}};
            default:   lane_data = value;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte or halfword from a memory read word.
// The extracted value is then zero- or sign-extended to 32 bits.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] memRData,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unsignedLoad,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        fill;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = memRData[7:0];
            2'd1:    byte_sel = memRData[15:8];
            2'd2:    byte_sel = memRData[23:16];
            default: byte_sel = memRData[31:24];
        endcase
        half_sel = offset[1] ? memRData[31:16] : memRData[15:0];
        fill     = 1'b0;
        case (size)
            SIZE_BYTE: begin
                fill   = ~unsignedLoad & byte_sel[7];
                result = {{24{fill}}, byte_sel};
            end
            SIZE_HALF: begin
                fill   = ~unsignedLoad & half_sel[15];
                result = {{16{fill}}, half_sel};
            end
            default:   result = memRData;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// EX/ME data-memory access unit: issues one request per instruction and stalls until it is acknowledged.
// A DONE bubble follows every access, so the frozen instruction can never be issued a second time.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] control,
    input  logic [31:0] aluR,
    input  logic [31:0] regTValue,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memByteEn,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic [31:0] loadData,
    output logic        stall,
    output logic        misaligned
);

    state_t      state, next_state;
    logic        mem_read, mem_write, unsigned_load;
    logic [1:0]  size;
    logic        access, bad, issue;
    logic [1:0]  lat_offset, lat_size;
    logic        lat_unsigned;
    logic [31:0] aligned;
    logic        unused_ctrl;

    assign mem_read      = control[CTRL_READ];
    assign mem_write     = control[CTRL_WRITE];
    assign size          = control[CTRL_SIZE_HI:CTRL_SIZE_LO];
    assign unsigned_load = control[CTRL_UNSIGNED];
    assign unused_ctrl   = &{1'b0, control[31:5]};

    assign access = mem_read ^ mem_write;
    assign bad    = (mem_read & mem_write) | (size == SIZE_RSVD)
                  | ((size == SIZE_HALF) & aluR[0])
                  | ((size == SIZE_WORD) & (aluR[1:0] != 2'b00));

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        memReq     = 1'b0;
        case (state)
            IDLE: begin
                if (access && !bad) begin
                    issue      = 1'b1;
                    stall      = 1'b1;
                    next_state = WAIT;
                end else if (mem_read || mem_write) begin
                    misaligned = 1'b1;
                end
            end
            WAIT: begin
                memReq = 1'b1;
                stall  = 1'b1;
                if (memAck) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Offset/size/sign are captured at issue so load formatting does not depend on later control changes
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            memWe        <= 1'b0;
            memAddr      <= '0;
            memByteEn    <= '0;
            memWData     <= '0;
            loadData     <= '0;
            lat_offset   <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
        end else begin
            state <= next_state;
            if (issue) begin
                memWe        <= mem_write;
                memAddr      <= {aluR[31:2], 2'b00};
                memByteEn    <= lane_enable(size, aluR[1:0]);
                memWData     <= lane_data(size, regTValue);
                lat_offset   <= aluR[1:0];
                lat_size     <= size;
                lat_unsigned <= unsigned_load;
            end
            if (state == WAIT && memAck && !memWe) loadData <= aligned;
        end
    end

    mem_load_align u_align (
        .memRData     (memRData),
        .offset       (lat_offset),
        .size         (lat_size),
        .unsignedLoad (lat_unsigned),
        .result       (aligned)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit; expected load results are queued at issue
// and popped once the access reaches its DONE cycle.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] control = '0;
    logic [31:0] aluR = '0;
    logic [31:0] regTValue = '0;
    logic        memAck = 1'b0;
    logic [31:0] memRData = '0;
    logic        memReq, memWe, stall, misaligned;
    logic [31:0] memAddr, memWData, loadData;
    logic [3:0]  memByteEn;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load = '0;
    logic [31:0] expv;
    int req_pulses = 0;
    logic req_prev = 1'b0;

    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_stable, obs_timeout;
    int          obs_stall;

    mem_access_unit dut (
        .clock      (clock),
        .reset      (reset),
        .control    (control),
        .aluR       (aluR),
        .regTValue  (regTValue),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memByteEn  (memByteEn),
        .memWData   (memWData),
        .memAck     (memAck),
        .memRData   (memRData),
        .loadData   (loadData),
        .stall      (stall),
        .misaligned (misaligned)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (memReq && !req_prev) req_pulses = req_pulses + 1;
        req_prev = memReq;
    end

    function automatic logic [31:0] mk_ctrl(input logic rd, input logic wr, input logic [1:0] sz, input logic uns);
        return {27'd0, uns, sz, wr, rd};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one access from its IDLE cycle through DONE; returns in the DONE cycle with control still held
    task automatic run_access(input logic [31:0] ctrl, input logic [31:0] addr, input logic [31:0] wval,
                              input logic [31:0] rdata, input int ack_at, input logic [31:0] exp_load);
        int k;
        obs_stall   = 0;
        obs_stable  = 1'b1;
        obs_timeout = 1'b0;
        control     = ctrl;
        aluR        = addr;
        regTValue   = wval;
        memAck      = 1'b0;
        exp_q.push_back(exp_load);
        #1;
        if (stall) obs_stall++;
        step();
        obs_addr  = memAddr;
        obs_be    = memByteEn;
        obs_wdata = memWData;
        obs_we    = memWe;
        if (!memReq) obs_timeout = 1'b1;
        k = 1;
        while (memReq && k <= 20) begin
            if (memAddr !== obs_addr || memByteEn !== obs_be || memWData !== obs_wdata || memWe !== obs_we)
                obs_stable = 1'b0;
            if (k == ack_at) begin
                memAck   = 1'b1;
                memRData = rdata;
            end else begin
                memAck = 1'b0;
            end
            #1;
            if (stall) obs_stall++;
            step();
            k++;
        end
        if (k > 20) obs_timeout = 1'b1;
        memAck   = 1'b0;
        memRData = 32'h5A5A_5A5A;
        #1;
        if (stall) obs_stall++;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        control = '0;
        step();
        step();
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", memReq); end
        total++; if (memWe !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", memWe); end
        total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", memAddr); end
        total++; if (memByteEn !== 4'h0) begin bad++; $display("FAIL reset_be got=%b want=0000", memByteEn); end
        total++; if (memWData !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", memWData); end
        total++; if (loadData !== 32'h0) begin bad++; $display("FAIL reset_load got=%h want=0", loadData); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b want=0", misaligned); end
        reset     = 1'b0;
        last_load = '0;
        step();
    endtask

    task automatic test_load_word();
        run_access(mk_ctrl(1'b1, 1'b0, 2'b10, 1'b0), 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
        total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL lw_timeout got=%b want=0", obs_timeout); end
        total++; if (obs_be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b want=1111", obs_be); end
        total++; if (obs_addr !== 32'h0000_1004) begin bad++; $display("FAIL lw_addr got=%h want=00001004", obs_addr); end
        total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b want=0", obs_we); end
        total++; if (obs_stall !== 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=3", obs_stall); end
        total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL lw_hold got=%b want=1", obs_stable); end
        expv = exp_q.pop_front();
        total++; if (loadData !== expv) begin bad++; $display("FAIL lw_load got=%h want=%h", loadData, expv); end
        last_load = expv;
        step();
        control = '0;
    endtask

    task automatic test_load_sub();
        logic [31:0] addrs[4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
        logic [31:0] rd[4]    = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h1234_8001};
        logic [1:0]  sz[4]    = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un[4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  be[4]    = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        logic [31:0] ld[4]    = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_8001};
        for (int i = 0; i < 4; i++) begin
            run_access(mk_ctrl(1'b1, 1'b0, sz[i], un[i]), addrs[i], 32'h0, rd[i], 1 + (i % 2), ld[i]);
            total++; if (obs_be !== be[i]) begin bad++; $display("FAIL sub_load_be[%0d] got=%b want=%b", i, obs_be, be[i]); end
            total++; if (obs_addr !== 32'h1000) begin bad++; $display("FAIL sub_load_addr[%0d] got=%h want=00001000", i, obs_addr); end
            expv = exp_q.pop_front();
            total++; if (loadData !== expv) begin bad++; $display("FAIL sub_load_data[%0d] got=%h want=%h", i, loadData, expv); end
            last_load = expv;
            step();
            control = '0;
        end
    endtask

    task automatic test_store();
        logic [31:0] addrs[3] = '{32'h2002, 32'h2001, 32'h2000};
        logic [31:0] val[3]   = '{32'h1234_ABCD, 32'h0000_0055, 32'hCAFE_BABE};
        logic [1:0]  sz[3]    = '{2'b01, 2'b00, 2'b10};
        logic [3:0]  be[3]    = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] wd[3]    = '{32'hABCD_ABCD, 32'h5555_5555, 32'hCAFE_BABE};
        for (int i = 0; i < 3; i++) begin
            run_access(mk_ctrl(1'b0, 1'b1, sz[i], 1'b0), addrs[i], val[i], 32'hFFFF_FFFF, i + 1, last_load);
            total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL store_we[%0d] got=%b want=1", i, obs_we); end
            total++; if (obs_be !== be[i]) begin bad++; $display("FAIL store_be[%0d] got=%b want=%b", i, obs_be, be[i]); end
            total++; if (obs_wdata !== wd[i]) begin bad++; $display("FAIL store_wdata[%0d] got=%h want=%h", i, obs_wdata, wd[i]); end
            total++; if (obs_addr !== 32'h2000) begin bad++; $display("FAIL store_addr[%0d] got=%h want=00002000", i, obs_addr); end
            total++; if (obs_stall !== i + 2) begin bad++; $display("FAIL store_stall[%0d] got=%0d want=%0d", i, obs_stall, i + 2); end
            expv = exp_q.pop_front();
            total++; if (loadData !== expv) begin bad++; $display("FAIL store_load_kept[%0d] got=%h want=%h", i, loadData, expv); end
            step();
            control = '0;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] ctl[5];
        logic [31:0] addrs[5] = '{32'h3001, 32'h3003, 32'h3002, 32'h3000, 32'h3000};
        int p0;
        ctl[0] = mk_ctrl(1'b1, 1'b0, 2'b10, 1'b0);
        ctl[1] = mk_ctrl(1'b1, 1'b0, 2'b01, 1'b0);
        ctl[2] = mk_ctrl(1'b0, 1'b1, 2'b10, 1'b0);
        ctl[3] = mk_ctrl(1'b1, 1'b1, 2'b10, 1'b0);
        ctl[4] = mk_ctrl(1'b1, 1'b0, 2'b11, 1'b0);
        p0 = req_pulses;
        for (int i = 0; i < 5; i++) begin
            control = ctl[i];
            aluR    = addrs[i];
            #1;
            total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL misaligned_flag[%0d] got=%b want=1", i, misaligned); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL misaligned_stall[%0d] got=%b want=0", i, stall); end
            step();
            total++; if (memReq !== 1'b0) begin bad++; $display("FAIL misaligned_req[%0d] got=%b want=0", i, memReq); end
        end
        control = mk_ctrl(1'b0, 1'b0, 2'b10, 1'b0);
        aluR    = 32'h3001;
        #1;
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL no_access_flag got=%b want=0", misaligned); end
        step();
        step();
        total++; if (req_pulses - p0 !== 0) begin bad++; $display("FAIL misaligned_pulses got=%0d want=0", req_pulses - p0); end
        control = '0;
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = req_pulses;
        run_access(mk_ctrl(1'b1, 1'b0, 2'b10, 1'b0), 32'h4000, 32'h0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b want=0", stall); end
        expv = exp_q.pop_front();
        total++; if (loadData !== expv) begin bad++; $display("FAIL b2b_load0 got=%h want=%h", loadData, expv); end
        step();
        run_access(mk_ctrl(1'b1, 1'b0, 2'b10, 1'b0), 32'h4004, 32'h0, 32'h7654_3210, 1, 32'h7654_3210);
        total++; if (obs_stall !== 2) begin bad++; $display("FAIL b2b_stall got=%0d want=2", obs_stall); end
        expv = exp_q.pop_front();
        total++; if (loadData !== expv) begin bad++; $display("FAIL b2b_load1 got=%h want=%h", loadData, expv); end
        last_load = expv;
        step();
        control = '0;
        step();
        step();
        total++; if (req_pulses - p0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", req_pulses - p0); end
    endtask

    task automatic test_reset_in_wait();
        int p0;
        control = mk_ctrl(1'b1, 1'b0, 2'b10, 1'b0);
        aluR    = 32'h5000;
        memAck  = 1'b0;
        step();
        total++; if (memReq !== 1'b1) begin bad++; $display("FAIL rst_wait_req1 got=%b want=1", memReq); end
        step();
        reset   = 1'b1;
        control = '0;
        step();
        reset    = 1'b0;
        memAck   = 1'b1;
        memRData = 32'hCAFE_F00D;
        p0 = req_pulses;
        #1;
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL rst_wait_req2 got=%b want=0", memReq); end
        step();
        memAck = 1'b0;
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL rst_wait_req3 got=%b want=0", memReq); end
        total++; if (loadData !== 32'h0) begin bad++; $display("FAIL rst_wait_load got=%h want=0", loadData); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_wait_stall got=%b want=0", stall); end
        total++; if (req_pulses - p0 !== 0) begin bad++; $display("FAIL rst_wait_pulses got=%0d want=0", req_pulses - p0); end
        run_access(mk_ctrl(1'b1, 1'b0, 2'b10, 1'b0), 32'h5008, 32'h0, 32'h1122_3344, 1, 32'h1122_3344);
        total++; if (obs_stall !== 2) begin bad++; $display("FAIL post_reset_stall got=%0d want=2", obs_stall); end
        expv = exp_q.pop_front();
        total++; if (loadData !== expv) begin bad++; $display("FAIL post_reset_load got=%h want=%h", loadData, expv); end
        last_load = expv;
        step();
        control = '0;
        memAck   = 1'b1;
        memRData = 32'hFEED_FACE;
        step();
        step();
        memAck = 1'b0;
        total++; if (loadData !== last_load) begin bad++; $display("FAIL idle_ack_ignored got=%h want=%h", loadData, last_load); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
